afe_serial_arbiter: RTL and testbench
=====================================

AFE_SERIAL_ARBITER -- requirements
Module: afe_serial_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2: number of cycles held after a start before serial_ready is sampled.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4095: maximum number of WAIT cycles per transaction (12-bit counter).
REQ-003 SHALL have port clk, input, 1: system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: permits new grants.
REQ-006 SHALL have port req, input, 3: per-requester request, held high until acked.
REQ-007 SHALL have ports cmd0, cmd1, cmd2, input, 20 each: requester AFE command words, stable while the matching req is high.
REQ-008 SHALL have port ack, output, 3: one-cycle pulse to the granted requester.
REQ-009 SHALL have port serial_ready, input, 1: serial engine idle.
REQ-010 SHALL have port afe_command, output, 20: latched winning command.
REQ-011 SHALL have port start_transaction, output, 1: one-cycle trigger to the serial engine.
REQ-012 SHALL have port grant_id, output, 2: index of the last granted requester.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port timeout_err, output, 1: sticky transaction timeout flag.
REQ-015 SHALL have port clear_err, input, 1: synchronous clear of timeout_err.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, ARB, START, HOLD and WAIT; all outputs SHALL be registered or decoded from the registered state.
REQ-017 IDLE SHALL go to ARB when enable=1, serial_ready=1 and req!=0; otherwise it SHALL stay in IDLE.
REQ-018 ARB SHALL pick the winner round-robin from req sampled in that cycle.
  - Search starts at (grant_id+1) mod 3 and wraps 2->0.
  - On a win: latch cmdN into afe_command, load grant_id, go to START.
  - If req=0 in ARB: go to IDLE with afe_command and grant_id unchanged.
REQ-019 In START, start_transaction=1 and ack[grant_id]=1 for exactly one cycle; next state SHALL be HOLD.
REQ-020 HOLD SHALL last exactly HOLD_CYCLES cycles and SHALL ignore serial_ready; next state SHALL be WAIT.
REQ-021 WAIT SHALL go to IDLE on the first cycle serial_ready=1.
REQ-022 In WAIT, if serial_ready has not returned after TIMEOUT_CYCLES cycles, timeout_err SHALL be set and the FSM SHALL go to IDLE.
REQ-023 Latency from req rising (while IDLE and ready) to start_transaction SHALL be 2 cycles; back-to-back grants SHALL be at least 3+HOLD_CYCLES cycles apart.
REQ-024 Deasserting enable SHALL only block IDLE->ARB; an in-flight transaction SHALL complete normally.
REQ-025 afe_command SHALL stay stable from START until the next ARB win.
REQ-026 timeout_err SHALL stay set until clear_err=1; if clear_err and a new timeout occur in the same cycle, set SHALL win.
REQ-027 A requester dropping req after grant but before ack SHALL still receive ack; a requester dropping req before ARB SHALL be skipped.
REQ-028 At most one bit of ack SHALL be high in any cycle, and only while start_transaction=1.

Reset
REQ-029 reset_n=0 SHALL asynchronously force the following values:
  - state=IDLE, ack=0, start_transaction=0, busy=0, timeout_err=0;
  - afe_command=0, grant_id=2 (so requester 0 wins first), all counters=0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no further start_transaction or ack; operation SHALL resume from IDLE after release.

Verification
REQ-031 Single request: req=001, cmd0=0x12345, serial_ready=1 -> start_transaction and ack=001 two cycles later, afe_command=0x12345, grant_id=0.
REQ-032 Fairness: req=111 held, serial_ready returns 1 cycle after HOLD -> grant order 0,1,2,0, each with a single ack pulse.
REQ-033 Serial busy: serial_ready=0 while req=010 -> no start; ready=1 -> start 2 cycles later.
REQ-034 Timeout: serial_ready stuck 0 after a start -> timeout_err=1 after HOLD_CYCLES+TIMEOUT_CYCLES cycles, FSM in IDLE; clear_err pulse -> timeout_err=0.
REQ-035 Enable and reset: enable=0 with req=100 -> no grant; reset during HOLD -> all outputs at reset values, grant_id=2.

Source files
------------

// File: rtl/afe_serial_arbiter.sv
// afe_serial_arbiter: round-robin arbiter granting one of three requesters
// access to a shared AFE serial engine. A Moore FSM latches the winning
// command, fires a one-cycle start/ack, holds for HOLD_CYCLES and then waits
// (with a timeout) for the serial engine to report idle again.
module afe_serial_arbiter #(
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [2:0]  req,
  input  logic [19:0] cmd0,
  input  logic [19:0] cmd1,
  input  logic [19:0] cmd2,
  output logic [2:0]  ack,
  input  logic        serial_ready,
  output logic [19:0] afe_command,
  output logic        start_transaction,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        timeout_err,
  input  logic        clear_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    START = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  // Terminal counts; both counters start at 0 on entry to their state.
  localparam logic [11:0] HOLD_LAST = 12'(HOLD_CYCLES - 1);
  localparam logic [11:0] TO_LAST   = 12'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [11:0] hold_cnt_q, hold_cnt_d;
  logic [11:0] wait_cnt_q, wait_cnt_d;
  logic [19:0] cmd_q, cmd_d;
  logic [1:0]  grant_q, grant_d;
  logic        terr_q, terr_d;

  logic        win_valid;
  logic [1:0]  win_id;
  logic [19:0] win_cmd;
  logic [1:0]  rr_base;
  logic [2:0]  cand;
  logic        timeout_hit;

  // Round-robin search starting one past the last grant, wrapping 2 -> 0.
  always_comb begin
    rr_base   = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
    win_valid = 1'b0;
    win_id    = 2'd0;
    cand      = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_base} + 3'(k);
      if (cand >= 3'd3) begin
        cand = cand - 3'd3;
      end
      if (!win_valid && req[cand[1:0]]) begin
        win_valid = 1'b1;
        win_id    = cand[1:0];
      end
    end
  end

  // Command word of the current round-robin winner.
  always_comb begin
    case (win_id)
      2'd0:    win_cmd = cmd0;
      2'd1:    win_cmd = cmd1;
      default: win_cmd = cmd2;
    endcase
  end

  // Next-state logic for the FSM, counters, latched command and error flag.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    cmd_d       = cmd_q;
    grant_d     = grant_q;
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && serial_ready && (req != 3'b000)) begin
          state_d = ARB;
        end
      end
      ARB: begin
        if (win_valid) begin
          grant_d = win_id;
          cmd_d   = win_cmd;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        hold_cnt_d = 12'd0;
        state_d    = HOLD;
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          wait_cnt_d = 12'd0;
          state_d    = WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q + 12'd1;
        end
      end
      WAIT: begin
        if (serial_ready) begin
          state_d = IDLE;
        end else if (wait_cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Sticky error: a new timeout overrides a simultaneous clear.
    terr_d = terr_q;
    if (clear_err) begin
      terr_d = 1'b0;
    end
    if (timeout_hit) begin
      terr_d = 1'b1;
    end
  end

  // State and datapath registers; grant resets to 2 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= 12'd0;
      wait_cnt_q <= 12'd0;
      cmd_q      <= 20'd0;
      grant_q    <= 2'd2;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      cmd_q      <= cmd_d;
      grant_q    <= grant_d;
      terr_q     <= terr_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    start_transaction = (state_q == START);
    ack               = start_transaction ? (3'b001 << grant_q) : 3'b000;
    busy              = (state_q != IDLE);
    afe_command       = cmd_q;
    grant_id          = grant_q;
    timeout_err       = terr_q;
  end

endmodule

// File: tb/tb_afe_serial_arbiter.sv
// Directed testbench for afe_serial_arbiter: reset values, single request,
// round-robin fairness, serial-busy stall, timeout, enable gating and
// reset during HOLD.
module tb_afe_serial_arbiter;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [2:0]  req;
  logic [19:0] cmd0, cmd1, cmd2;
  logic [2:0]  ack;
  logic        serial_ready;
  logic [19:0] afe_command;
  logic        start_transaction;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic        clear_err;

  int vectors;
  int miscompares;

  afe_serial_arbiter #(.HOLD_CYCLES(2), .TIMEOUT_CYCLES(4095)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .req               (req),
    .cmd0              (cmd0),
    .cmd1              (cmd1),
    .cmd2              (cmd2),
    .ack               (ack),
    .serial_ready      (serial_ready),
    .afe_command       (afe_command),
    .start_transaction (start_transaction),
    .grant_id          (grant_id),
    .busy              (busy),
    .timeout_err       (timeout_err),
    .clear_err         (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("vec %0d %s: observed 0x%0h expected 0x%0h", vectors, tag, obs, exp);
  endtask

  // Tick until start_transaction is seen, bounded; returns cycles taken.
  task automatic wait_start(input int max, output int n);
    n = 0;
    while (start_transaction !== 1'b1 && n < max) begin
      tick(1);
      n++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  int          n;
  logic [1:0]  exp_ids [4];
  logic [19:0] exp_cmd;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    exp_ids[0]   = 2'd0;
    exp_ids[1]   = 2'd1;
    exp_ids[2]   = 2'd2;
    exp_ids[3]   = 2'd0;
    reset_n      = 1'b0;
    enable       = 1'b1;
    req          = 3'b000;
    cmd0         = 20'h12345;
    cmd1         = 20'hABCDE;
    cmd2         = 20'h0F0F0;
    serial_ready = 1'b1;
    clear_err    = 1'b0;

    // Reset values
    tick(2);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_start", 32'(start_transaction), 32'd0);
    chk("rst_ack",   32'(ack), 32'd0);
    chk("rst_terr",  32'(timeout_err), 32'd0);
    chk("rst_cmd",   32'(afe_command), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd2);
    reset_n = 1'b1;
    tick(1);

    // Single request from requester 0
    req = 3'b001;
    tick(1);
    chk("single_arb_start", 32'(start_transaction), 32'd0);
    chk("single_arb_busy",  32'(busy), 32'd1);
    tick(1);
    chk("single_start", 32'(start_transaction), 32'd1);
    chk("single_ack",   32'(ack), 32'b001);
    chk("single_cmd",   32'(afe_command), 32'h12345);
    chk("single_grant", 32'(grant_id), 32'd0);
    req = 3'b000;
    tick(1);
    chk("single_hold_start", 32'(start_transaction), 32'd0);
    chk("single_hold_ack",   32'(ack), 32'd0);
    tick(2);
    chk("single_wait_busy", 32'(busy), 32'd1);
    tick(1);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_cmd_kept",  32'(afe_command), 32'h12345);

    // Fairness: all three requesting, grant order 0,1,2,0
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_start(20, n);
      chk($sformatf("rr%0d_latency", i), 32'(n), (i == 0) ? 32'd2 : 32'd3);
      chk($sformatf("rr%0d_grant", i), 32'(grant_id), 32'(exp_ids[i]));
      chk($sformatf("rr%0d_ack", i), 32'(ack), 32'(3'b001 << exp_ids[i]));
      case (exp_ids[i])
        2'd0:    exp_cmd = 20'h12345;
        2'd1:    exp_cmd = 20'hABCDE;
        default: exp_cmd = 20'h0F0F0;
      endcase
      chk($sformatf("rr%0d_cmd", i), 32'(afe_command), 32'(exp_cmd));
      serial_ready = 1'b0;
      tick(1);
      chk($sformatf("rr%0d_ack_pulse", i), 32'(ack), 32'd0);
      tick(2);
      serial_ready = 1'b1;
    end
    req = 3'b000;
    tick(5);
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Serial engine busy: no start until ready returns
    serial_ready = 1'b0;
    req = 3'b010;
    tick(5);
    chk("sbusy_no_start", 32'(start_transaction), 32'd0);
    chk("sbusy_idle",     32'(busy), 32'd0);
    serial_ready = 1'b1;
    wait_start(20, n);
    chk("sbusy_latency", 32'(n), 32'd2);
    chk("sbusy_grant",   32'(grant_id), 32'd1);
    chk("sbusy_cmd",     32'(afe_command), 32'hABCDE);

    // Timeout: ready stuck low after the start
    req = 3'b000;
    serial_ready = 1'b0;
    tick(4097);
    chk("to_before_terr", 32'(timeout_err), 32'd0);
    chk("to_before_busy", 32'(busy), 32'd1);
    tick(1);
    chk("to_terr", 32'(timeout_err), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    tick(3);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("to_cleared", 32'(timeout_err), 32'd0);

    // Enable gating
    serial_ready = 1'b1;
    enable = 1'b0;
    req = 3'b100;
    tick(4);
    chk("en_off_start", 32'(start_transaction), 32'd0);
    chk("en_off_busy",  32'(busy), 32'd0);
    enable = 1'b1;
    wait_start(20, n);
    chk("en_on_latency", 32'(n), 32'd2);
    chk("en_on_grant",   32'(grant_id), 32'd2);
    chk("en_on_ack",     32'(ack), 32'b100);
    chk("en_on_cmd",     32'(afe_command), 32'h0F0F0);
    req = 3'b000;
    tick(4);
    chk("en_done_idle", 32'(busy), 32'd0);

    // Reset during HOLD aborts the transaction
    req = 3'b001;
    wait_start(20, n);
    chk("rh_latency", 32'(n), 32'd2);
    chk("rh_grant",   32'(grant_id), 32'd0);
    req = 3'b000;
    tick(1);
    reset_n = 1'b0;
    #2;
    chk("rh_busy",  32'(busy), 32'd0);
    chk("rh_grant_rst", 32'(grant_id), 32'd2);
    chk("rh_cmd",   32'(afe_command), 32'd0);
    chk("rh_start", 32'(start_transaction), 32'd0);
    chk("rh_ack",   32'(ack), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("rh_after_start", 32'(start_transaction), 32'd0);
    chk("rh_after_busy",  32'(busy), 32'd0);
    req = 3'b001;
    wait_start(20, n);
    chk("rh_resume_latency", 32'(n), 32'd2);
    chk("rh_resume_ack",     32'(ack), 32'b001);
    req = 3'b000;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
